// File: rtl/uart_pkg.sv
// Shared definitions for the bus UART: register offsets, STATUS bit positions and FSM states.
package uart_pkg;

    localparam logic [1:0] REG_TXDATA  = 2'd0;
    localparam logic [1:0] REG_RXDATA  = 2'd1;
    localparam logic [1:0] REG_STATUS  = 2'd2;
    localparam logic [1:0] REG_DIVISOR = 2'd3;

    localparam int ST_TX_FULL  = 0;
    localparam int ST_TX_EMPTY = 1;
    localparam int ST_RX_VALID = 2;
    localparam int ST_OVERRUN  = 3;
    localparam int ST_COUNT    = 8;

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

endpackage

// File: rtl/bus_uart_if.sv
// Single-cycle CPU data bus as seen by a peripheral: comb. request in, registered read data back.
interface bus_uart_if;
    logic        sel;
    logic [1:0]  addr;
    logic [31:0] data_w;
    logic [3:0]  mask_w;
    logic [31:0] data_r;

    modport master (output sel, addr, data_w, mask_w, input data_r);
    modport slave  (input sel, addr, data_w, mask_w, output data_r);
endinterface

// File: rtl/sync_fifo.sv
// Synchronous FIFO with occupancy count; pushes when full and pops when empty are ignored.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (push_ok) mem[wr_ptr] <= din;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            if (push_ok && !pop_ok)      count <= count + 1'b1;
            else if (pop_ok && !push_ok) count <= count - 1'b1;
        end
    end
endmodule

// File: rtl/bus_uart.sv
// Memory-mapped UART: TX byte FIFO feeding a shift FSM, RX sampler with a one-byte holding register.
module bus_uart
    import uart_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int DIV_WIDTH  = 16,
    parameter int DIV_RESET  = 868
) (
    input  logic        clock,
    input  logic        reset,
    bus_uart_if.slave   bus,
    output logic        tx,
    input  logic        rx,
    output logic        irq
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic                 wr_en, rd_en, rd_rx, ovr_clr;
    logic [DIV_WIDTH-1:0] divisor, div_eff, div_last, rx_half;
    logic                 fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [7:0]           fifo_dout;
    logic [CW-1:0]        fifo_count;
    tx_state_t            tx_state;
    logic [DIV_WIDTH-1:0] tx_cnt;
    logic [2:0]           tx_bit;
    logic [7:0]           tx_shift;
    rx_state_t            rx_state;
    logic [DIV_WIDTH-1:0] rx_cnt;
    logic [2:0]           rx_bit;
    logic [7:0]           rx_shift, rx_byte;
    logic                 rx_s1, rx_s2, rx_s3;
    logic                 rx_valid, rx_valid_nxt, rx_done, overrun;
    logic [31:0]          status;
    logic                 unused_data;

    assign wr_en     = bus.sel && (bus.mask_w != 4'b0);
    assign rd_en     = bus.sel && (bus.mask_w == 4'b0);
    assign rd_rx     = rd_en && (bus.addr == REG_RXDATA);
    assign ovr_clr   = wr_en && (bus.addr == REG_STATUS) && bus.mask_w[0] && bus.data_w[ST_OVERRUN];
    assign div_eff   = (divisor == '0) ? DIV_WIDTH'(1) : divisor;
    assign div_last  = div_eff - DIV_WIDTH'(1);
    assign rx_half   = div_eff >> 1;
    assign fifo_push = wr_en && (bus.addr == REG_TXDATA) && bus.mask_w[0];
    assign fifo_pop  = !fifo_empty &&
                       ((tx_state == TX_IDLE) || (tx_state == TX_STOP && tx_cnt == '0));
    assign rx_done   = (rx_state == RX_STOP) && (rx_cnt == '0) && rx_s2;
    // A read racing a completion keeps the flag set: the CPU saw the old byte, not the new one.
    assign rx_valid_nxt = rx_done || (rx_valid && !rd_rx);
    assign unused_data  = ^bus.data_w;

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (fifo_push),
        .din   (bus.data_w[7:0]),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            divisor <= DIV_WIDTH'(DIV_RESET);
        end else if (wr_en && bus.addr == REG_DIVISOR) begin
            for (int b = 0; b < DIV_WIDTH; b++)
                if (bus.mask_w[b/8]) divisor[b] <= bus.data_w[b];
        end
    end

    // Every state holds for div_eff cycles; the counter reloads from the live divisor on entry.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tx_state <= TX_IDLE;
            tx       <= 1'b1;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
        end else begin
            case (tx_state)
                TX_IDLE: begin
                    if (fifo_pop) begin
                        tx_state <= TX_START;
                        tx       <= 1'b0;
                        tx_shift <= fifo_dout;
                        tx_cnt   <= div_last;
                    end
                end
                TX_START: begin
                    if (tx_cnt == '0) begin
                        tx_state <= TX_DATA;
                        tx       <= tx_shift[0];
                        tx_shift <= {1'b0, tx_shift[7:1]};
                        tx_bit   <= '0;
                        tx_cnt   <= div_last;
                    end else tx_cnt <= tx_cnt - 1'b1;
                end
                TX_DATA: begin
                    if (tx_cnt == '0) begin
                        tx_cnt <= div_last;
                        if (tx_bit == 3'd7) begin
                            tx_state <= TX_STOP;
                            tx       <= 1'b1;
                        end else begin
                            tx       <= tx_shift[0];
                            tx_shift <= {1'b0, tx_shift[7:1]};
                            tx_bit   <= tx_bit + 1'b1;
                        end
                    end else tx_cnt <= tx_cnt - 1'b1;
                end
                TX_STOP: begin
                    if (tx_cnt == '0) begin
                        if (fifo_pop) begin
                            tx_state <= TX_START;
                            tx       <= 1'b0;
                            tx_shift <= fifo_dout;
                            tx_cnt   <= div_last;
                        end else tx_state <= TX_IDLE;
                    end else tx_cnt <= tx_cnt - 1'b1;
                end
                default: tx_state <= TX_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
            rx_s3 <= 1'b1;
        end else begin
            rx_s1 <= rx;
            rx_s2 <= rx_s1;
            rx_s3 <= rx_s2;
        end
    end

    // Samples land mid-bit: half a bit after the start edge, then one full bit apart.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
            rx_byte  <= '0;
            rx_valid <= 1'b0;
            overrun  <= 1'b0;
            irq      <= 1'b0;
        end else begin
            rx_valid <= rx_valid_nxt;
            irq      <= rx_valid_nxt;
            if (rx_done) rx_byte <= rx_shift;
            if (rx_done && rx_valid && !rd_rx) overrun <= 1'b1;
            else if (ovr_clr)                  overrun <= 1'b0;
            case (rx_state)
                RX_IDLE: begin
                    if (rx_s3 && !rx_s2) begin
                        rx_state <= RX_START;
                        rx_cnt   <= (rx_half == '0) ? '0 : rx_half - 1'b1;
                    end
                end
                RX_START: begin
                    if (rx_cnt == '0) begin
                        rx_state <= rx_s2 ? RX_IDLE : RX_DATA;
                        rx_bit   <= '0;
                        rx_cnt   <= div_last;
                    end else rx_cnt <= rx_cnt - 1'b1;
                end
                RX_DATA: begin
                    if (rx_cnt == '0) begin
                        rx_shift <= {rx_s2, rx_shift[7:1]};
                        rx_cnt   <= div_last;
                        if (rx_bit == 3'd7) rx_state <= RX_STOP;
                        else                rx_bit   <= rx_bit + 1'b1;
                    end else rx_cnt <= rx_cnt - 1'b1;
                end
                RX_STOP: begin
                    if (rx_cnt == '0) rx_state <= RX_IDLE;
                    else              rx_cnt   <= rx_cnt - 1'b1;
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    always_comb begin
        status                 = '0;
        status[ST_TX_FULL]     = fifo_full;
        status[ST_TX_EMPTY]    = fifo_empty && (tx_state == TX_IDLE);
        status[ST_RX_VALID]    = rx_valid;
        status[ST_OVERRUN]     = overrun;
        status[ST_COUNT +: CW] = fifo_count;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            bus.data_r <= '0;
        end else if (rd_en) begin
            case (bus.addr)
                REG_RXDATA:  bus.data_r <= {23'b0, rx_valid, rx_byte};
                REG_STATUS:  bus.data_r <= status;
                REG_DIVISOR: bus.data_r <= 32'(divisor);
                default:     bus.data_r <= '0;
            endcase
        end else begin
            bus.data_r <= '0;
        end
    end
endmodule

// File: tb/tb_bus_uart.sv
// Self-checking bench for bus_uart: register table, TX frame scoreboard with a bit-exact line monitor, RX scenarios.
module tb_bus_uart;
    import uart_pkg::*;

    typedef struct {
        logic        sel;
        logic [1:0]  addr;
        logic [31:0] data;
        logic [3:0]  mask;
        logic [31:0] exp;
        string       name;
    } vec_t;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic rx    = 1'b1;
    logic tx, irq;

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;
    int cur_div    = 868;
    bit mon_busy   = 1'b0;

    logic [7:0]  tx_exp_q[$];
    logic [31:0] rx_exp_q[$];
    int          frame_starts[$];
    vec_t        vecs[$];

    bus_uart_if bus();

    bus_uart #(.FIFO_DEPTH(16), .DIV_WIDTH(16), .DIV_RESET(868)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus),
        .tx    (tx),
        .rx    (rx),
        .irq   (irq)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: time limit reached, got cycle %0d, required completion", cyc);
        $fatal(1, "[TB] simulation timeout");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // One bus request; returns data_r as registered for that request.
    task automatic applyStimulus(input logic s, input logic [1:0] a, input logic [31:0] d,
                                 input logic [3:0] m, output logic [31:0] r);
        bus.sel    = s;
        bus.addr   = a;
        bus.data_w = d;
        bus.mask_w = m;
        @(posedge clock);
        #1;
        r          = bus.data_r;
        bus.sel    = 1'b0;
        bus.mask_w = 4'h0;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d, input logic [3:0] m);
        logic [31:0] r;
        applyStimulus(1'b1, a, d, m, r);
    endtask

    task automatic bus_read(input logic [1:0] a, input logic [31:0] exp, input string name);
        logic [31:0] r;
        applyStimulus(1'b1, a, 32'h0, 4'h0, r);
        checkOutput(name, r, exp);
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic add_vec(input logic s, input logic [1:0] a, input logic [31:0] d,
                           input logic [3:0] m, input logic [31:0] e, input string name);
        vec_t v;
        v.sel = s; v.addr = a; v.data = d; v.mask = m; v.exp = e; v.name = name;
        vecs.push_back(v);
    endtask

    task automatic wait_tx_idle(input int budget, input string name);
        int n = 0;
        while ((tx_exp_q.size() != 0 || mon_busy) && n < budget) begin
            @(posedge clock);
            #1;
            n++;
        end
        compared++;
        if (n >= budget) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d frames still pending, expected 0 within %0d cycles",
                     name, tx_exp_q.size(), budget);
        end
    endtask

    task automatic wait_irq(input int budget, input string name);
        int n = 0;
        while (irq !== 1'b1 && n < budget) begin
            @(posedge clock);
            #1;
            n++;
        end
        checkOutput(name, {31'b0, irq}, 32'h1);
    endtask

    // Drives one frame on rx; the expected RXDATA value is queued, replacing an unread one.
    task automatic drive_rx_frame(input logic [7:0] b, input int div);
        if (rx_exp_q.size() != 0) void'(rx_exp_q.pop_back());
        rx_exp_q.push_back({23'b0, 1'b1, b});
        rx = 1'b0;
        idle_cycles(div);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            idle_cycles(div);
        end
        rx = 1'b1;
        idle_cycles(div);
    endtask

    task automatic read_rxdata(input string name);
        logic [31:0] e;
        if (rx_exp_q.size() == 0) e = 32'h0;
        else                      e = rx_exp_q.pop_front();
        bus_read(REG_RXDATA, e, name);
    endtask

    // Line monitor: on each start edge pops the expected byte and checks every cycle of the frame.
    initial begin : tx_monitor
        logic       prev;
        logic [7:0] exp;
        logic [9:0] bits;
        bit         ok, aborted, unexpected;
        int         bad_j;
        logic       bad_v;
        prev = 1'b1;
        forever begin
            @(negedge clock);
            if (reset && prev && tx === 1'b0) begin
                mon_busy = 1'b1;
                frame_starts.push_back(cyc);
                unexpected = (tx_exp_q.size() == 0);
                exp        = unexpected ? 8'h00 : tx_exp_q.pop_front();
                bits       = {1'b1, exp, 1'b0};
                ok         = !unexpected;
                aborted    = 1'b0;
                bad_j      = -1;
                bad_v      = 1'b0;
                for (int j = 0; j < 10 * cur_div; j++) begin
                    if (j > 0) @(negedge clock);
                    if (!reset) begin
                        aborted = 1'b1;
                        break;
                    end
                    if (tx !== bits[j / cur_div] && bad_j < 0) begin
                        ok    = 1'b0;
                        bad_j = j;
                        bad_v = tx;
                    end
                end
                if (!aborted) begin
                    compared++;
                    if (!ok) begin
                        mismatched++;
                        $display("[TB] FAIL tx_frame_%02h: got tx=%b at frame cycle %0d (unexpected=%0b), expected %b",
                                 exp, bad_v, bad_j, unexpected, (bad_j < 0) ? 1'b0 : bits[bad_j / cur_div]);
                    end
                end
                mon_busy = 1'b0;
            end
            prev = tx;
        end
    end

    initial begin : main
        logic [31:0] r;
        bit          gaps_ok;
        bus.sel    = 1'b0;
        bus.addr   = 2'd0;
        bus.data_w = 32'h0;
        bus.mask_w = 4'h0;

        #12;
        checkOutput("reset_tx", {31'b0, tx}, 32'h1);
        checkOutput("reset_irq", {31'b0, irq}, 32'h0);
        checkOutput("reset_data_r", bus.data_r, 32'h0);
        #9;
        reset = 1'b1;
        idle_cycles(1);
        $display("[TB] reset released at cycle %0d", cyc);

        add_vec(1'b1, REG_STATUS,  32'h0,         4'h0, 32'h0000_0002, "status_reset");
        add_vec(1'b1, REG_DIVISOR, 32'h0,         4'h0, 32'h0000_0364, "divisor_reset");
        add_vec(1'b1, REG_RXDATA,  32'h0,         4'h0, 32'h0000_0000, "rxdata_reset");
        add_vec(1'b1, REG_TXDATA,  32'h0,         4'h0, 32'h0000_0000, "txdata_read_zero");
        add_vec(1'b1, REG_DIVISOR, 32'hABCD_1234, 4'h1, 32'h0000_0000, "div_write_lane0");
        add_vec(1'b1, REG_DIVISOR, 32'h0,         4'h0, 32'h0000_0334, "div_lane0_readback");
        add_vec(1'b1, REG_DIVISOR, 32'hFFFF_56FF, 4'h2, 32'h0000_0000, "div_write_lane1");
        add_vec(1'b1, REG_DIVISOR, 32'h0,         4'h0, 32'h0000_5634, "div_lane1_readback");
        add_vec(1'b1, REG_DIVISOR, 32'h1234_0000, 4'hC, 32'h0000_0000, "div_write_upper");
        add_vec(1'b1, REG_DIVISOR, 32'h0,         4'h0, 32'h0000_5634, "div_upper_ignored");
        add_vec(1'b0, REG_DIVISOR, 32'h0,         4'h0, 32'h0000_0000, "no_sel_zero");
        add_vec(1'b1, REG_STATUS,  32'hFFFF_FFFF, 4'hF, 32'h0000_0000, "status_write");
        add_vec(1'b1, REG_STATUS,  32'h0,         4'h0, 32'h0000_0002, "status_unchanged");
        add_vec(1'b1, REG_DIVISOR, 32'h0000_0000, 4'h3, 32'h0000_0000, "div_write_zero");
        add_vec(1'b1, REG_DIVISOR, 32'h0,         4'h0, 32'h0000_0000, "div_zero_readback");
        foreach (vecs[i]) begin
            applyStimulus(vecs[i].sel, vecs[i].addr, vecs[i].data, vecs[i].mask, r);
            checkOutput(vecs[i].name, r, vecs[i].exp);
        end

        // Divisor 0 must behave as one cycle per bit.
        cur_div = 1;
        tx_exp_q.push_back(8'hC3);
        bus_write(REG_TXDATA, 32'h0000_00C3, 4'h1);
        wait_tx_idle(100, "tx_div0_done");

        bus_write(REG_DIVISOR, 32'h0000_0004, 4'h3);
        cur_div = 4;
        tx_exp_q.push_back(8'h55);
        bus_write(REG_TXDATA, 32'h0000_0055, 4'h1);
        checkOutput("tx_high_after_write", {31'b0, tx}, 32'h1);
        idle_cycles(1);
        checkOutput("tx_start_edge", {31'b0, tx}, 32'h0);
        idle_cycles(39);
        bus_read(REG_STATUS, 32'h0000_0000, "status_busy_last_stop");
        bus_read(REG_STATUS, 32'h0000_0002, "status_empty_after_frame");
        wait_tx_idle(50, "tx_55_done");

        bus_write(REG_DIVISOR, 32'h0000_0014, 4'h3);
        cur_div = 20;
        frame_starts.delete();
        for (int k = 0; k < 18; k++) begin
            if (k <= 16) tx_exp_q.push_back(8'(k));
            bus_write(REG_TXDATA, 32'(k), 4'h1);
        end
        bus_read(REG_STATUS, 32'h0000_1001, "status_fifo_full");
        wait_tx_idle(17 * 200 + 200, "tx_burst_done");
        checkOutput("burst_frame_count", 32'(frame_starts.size()), 32'd17);
        gaps_ok = 1'b1;
        for (int i = 1; i < frame_starts.size(); i++)
            if (frame_starts[i] - frame_starts[i-1] != 200) gaps_ok = 1'b0;
        checkOutput("burst_back_to_back", {31'b0, gaps_ok}, 32'h1);

        bus_write(REG_DIVISOR, 32'h0000_0008, 4'h3);
        drive_rx_frame(8'hA3, 8);
        wait_irq(50, "irq_after_rx");
        read_rxdata("rxdata_a3");
        bus_read(REG_STATUS, 32'h0000_0002, "status_after_rx_read");
        checkOutput("irq_cleared", {31'b0, irq}, 32'h0);

        drive_rx_frame(8'h12, 8);
        drive_rx_frame(8'h34, 8);
        idle_cycles(2);
        bus_read(REG_STATUS, 32'h0000_000E, "status_overrun");
        read_rxdata("rxdata_overrun_34");
        bus_write(REG_STATUS, 32'h0000_0008, 4'h1);
        bus_read(REG_STATUS, 32'h0000_0002, "status_overrun_cleared");

        rx = 1'b0;
        idle_cycles(2);
        rx = 1'b1;
        idle_cycles(40);
        checkOutput("glitch_no_irq", {31'b0, irq}, 32'h0);
        bus_read(REG_STATUS, 32'h0000_0002, "glitch_status");

        bus_write(REG_DIVISOR, 32'h0000_0004, 4'h3);
        cur_div = 4;
        tx_exp_q.push_back(8'h00);
        bus_write(REG_TXDATA, 32'h0000_0000, 4'h1);
        idle_cycles(10);
        checkOutput("tx_in_data_bit", {31'b0, tx}, 32'h0);
        #1;
        reset = 1'b0;
        #1;
        checkOutput("tx_async_reset", {31'b0, tx}, 32'h1);
        tx_exp_q.delete();
        idle_cycles(2);
        reset = 1'b1;
        cur_div = 868;
        bus_read(REG_STATUS, 32'h0000_0002, "status_after_midframe_reset");
        bus_read(REG_DIVISOR, 32'h0000_0364, "divisor_after_midframe_reset");
        checkOutput("tx_idle_after_reset", {31'b0, tx}, 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
